// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: received word, its valid/ready
// handshake, and the per-frame status pulses.
interface uart_rx_if #(
    parameter int N_DATA_BITS = 7
);
    logic [N_DATA_BITS-1:0] o_uart_data;
    logic                   o_uart_data_valid;
    logic                   i_uart_data_ready;
    logic                   o_uart_frame_err;
    logic                   o_uart_overrun;
    logic                   o_uart_busy;

    modport master (
        output o_uart_data,
        output o_uart_data_valid,
        input  i_uart_data_ready,
        output o_uart_frame_err,
        output o_uart_overrun,
        output o_uart_busy
    );

    modport slave (
        input  o_uart_data,
        input  o_uart_data_valid,
        output i_uart_data_ready,
        input  o_uart_frame_err,
        input  o_uart_overrun,
        input  o_uart_busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit glitch rejection, mid-bit sampling,
// one-word output buffer with valid/ready handshake, frame-error and overrun pulses.
module uart_rx #(
    parameter int N_DATA_BITS = 7,
    parameter int OVERSAMPLE  = 16
) (
    input  logic      i_uart_clk,
    input  logic      i_uart_reset,
    input  logic      i_uart_en,
    input  logic      i_uart_rx,
    uart_rx_if.master bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(N_DATA_BITS) + 1;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic                   r_rx_meta;
    logic                   r_rx_sync;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_tick_cnt;
    logic [IDX_W-1:0]       r_bit_idx;
    logic [N_DATA_BITS-1:0] r_shift;
    logic                   r_wait_high;
    logic [N_DATA_BITS-1:0] r_data;
    logic                   r_data_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   w_stop_tick;

    always_ff @(posedge i_uart_clk) begin
        if (i_uart_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_stop_tick = i_uart_en && (r_state == S_STOP) && (r_tick_cnt == FULL_CNT);

    // After a bad stop bit the line may still be low (break); r_wait_high keeps
    // IDLE from treating that as a new start edge until the line returns high.
    always_ff @(posedge i_uart_clk) begin
        if (i_uart_reset) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_wait_high <= 1'b0;
        end else if (i_uart_en) begin
            case (r_state)
                S_IDLE: begin
                    if (r_wait_high) begin
                        if (r_rx_sync) begin
                            r_wait_high <= 1'b0;
                        end
                    end else if (!r_rx_sync) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (r_tick_cnt == HALF_CNT) begin
                        r_tick_cnt <= '0;
                        if (!r_rx_sync) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (r_tick_cnt == FULL_CNT) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {r_rx_sync, r_shift[N_DATA_BITS-1:1]};
                        if (r_bit_idx == LAST_IDX) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_ONE;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (r_tick_cnt == FULL_CNT) begin
                        r_tick_cnt <= '0;
                        r_state    <= S_IDLE;
                        if (!r_rx_sync) begin
                            r_wait_high <= 1'b1;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A word being consumed on the same clock as a new stop bit frees the buffer,
    // so the new word replaces it without an overrun.
    always_ff @(posedge i_uart_clk) begin
        if (i_uart_reset) begin
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (bus.i_uart_data_ready) begin
                r_data_valid <= 1'b0;
            end
            if (w_stop_tick) begin
                if (r_rx_sync) begin
                    if (!r_data_valid || bus.i_uart_data_ready) begin
                        r_data       <= r_shift;
                        r_data_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign bus.o_uart_data       = r_data;
    assign bus.o_uart_data_valid = r_data_valid;
    assign bus.o_uart_frame_err  = r_frame_err;
    assign bus.o_uart_overrun    = r_overrun;
    assign bus.o_uart_busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: a behavioural transmitter drives whole frames tick by tick
// and the expected words, pulse counts and stop-sample timing come from frame arithmetic.
module tb_uart_rx;
    localparam int N  = 7;
    localparam int OS = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic en    = 1'b0;
    logic rx    = 1'b1;

    uart_rx_if #(.N_DATA_BITS(N)) bus ();

    uart_rx #(
        .N_DATA_BITS(N),
        .OVERSAMPLE (OS)
    ) dut (
        .i_uart_clk  (clk),
        .i_uart_reset(reset),
        .i_uart_en   (en),
        .i_uart_rx   (rx),
        .bus         (bus)
    );

    int n_vec    = 0;
    int n_mis    = 0;
    int cyc      = 0;
    int en_div   = 4;
    int div_cnt  = 0;
    int rise_cyc = -1;
    int stop_cyc = -1;
    int n_rise   = 0;
    int n_err    = 0;
    int n_ovr    = 0;
    logic       prev_valid = 1'b0;
    logic [N-1:0] rx_q[$];

    always #5 clk = ~clk;

    // Negedge housekeeping: oversample strobe generation and output observation.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            div_cnt = (div_cnt + 1 >= en_div) ? 0 : div_cnt + 1;
            en = (div_cnt == 0);
            if (bus.o_uart_data_valid === 1'b1 && prev_valid !== 1'b1) begin
                rise_cyc = cyc;
                n_rise++;
            end
            prev_valid = bus.o_uart_data_valid;
            if (bus.o_uart_frame_err === 1'b1) n_err++;
            if (bus.o_uart_overrun === 1'b1) n_ovr++;
            if (bus.o_uart_data_valid === 1'b1 && bus.i_uart_data_ready === 1'b1)
                rx_q.push_back(bus.o_uart_data);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_tick();
        do @(posedge clk); while (en !== 1'b1);
    endtask

    // Line falls just after tick 0; the receiver can act on it 3 clocks later,
    // reaches start-bit middle half a bit after that, and the stop middle N+1 bits later.
    function automatic int stop_tick();
        return (3 + en_div - 1) / en_div + OS / 2 + OS * (N + 1);
    endfunction

    task automatic pulse_ready();
        bus.i_uart_data_ready = 1'b1;
        @(posedge clk);
        #1 bus.i_uart_data_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic stop_bit,
                              input bit ready_at_stop, input int abort_at);
        logic [N+1:0] f;
        int st;
        f  = {stop_bit, d, 1'b0};
        st = stop_tick();
        wait_tick();
        for (int t = 0; t < (N + 2) * OS; t++) begin
            if (t == abort_at) break;
            #1;
            if (t % OS == 0) rx = f[t / OS];
            if (ready_at_stop && t + 1 == st) begin
                repeat (en_div - 1) @(posedge clk);
                #1 bus.i_uart_data_ready = 1'b1;
            end
            wait_tick();
            if (t + 1 == st) begin
                stop_cyc = cyc;
                if (ready_at_stop) #1 bus.i_uart_data_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        bus.i_uart_data_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.o_uart_data !== 7'h00) begin n_mis++; $display("[TB] FAIL reset_data: got %h expected %h", bus.o_uart_data, 7'h00); end
        n_vec++; if (bus.o_uart_data_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.o_uart_data_valid); end
        n_vec++; if (bus.o_uart_frame_err !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_frame_err: got %b expected 0", bus.o_uart_frame_err); end
        n_vec++; if (bus.o_uart_overrun !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.o_uart_overrun); end
        n_vec++; if (bus.o_uart_busy !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.o_uart_busy); end
        reset = 1'b0;
        repeat (20) wait_tick();
        @(negedge clk);
        n_vec++; if (bus.o_uart_busy !== 1'b0) begin n_mis++; $display("[TB] FAIL idle_busy: got %b expected 0", bus.o_uart_busy); end
    endtask

    task automatic test_basic();
        int r0;
        r0 = n_rise;
        rise_cyc = -1;
        send_frame(7'h55, 1'b1, 1'b0, -1);
        @(negedge clk);
        n_vec++; if (rise_cyc !== stop_cyc + 1) begin n_mis++; $display("[TB] FAIL basic_latency: got cycle %0d expected %0d", rise_cyc, stop_cyc + 1); end
        n_vec++; if (bus.o_uart_data !== 7'h55) begin n_mis++; $display("[TB] FAIL basic_data: got %h expected %h", bus.o_uart_data, 7'h55); end
        n_vec++; if (n_rise - r0 !== 1) begin n_mis++; $display("[TB] FAIL basic_valid_rises: got %0d expected 1", n_rise - r0); end
        repeat (40) @(negedge clk);
        n_vec++; if (bus.o_uart_data_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL basic_valid_held: got %b expected 1", bus.o_uart_data_valid); end
        n_vec++; if (bus.o_uart_data !== 7'h55) begin n_mis++; $display("[TB] FAIL basic_data_held: got %h expected %h", bus.o_uart_data, 7'h55); end
        pulse_ready();
        @(negedge clk);
        n_vec++; if (bus.o_uart_data_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL basic_consume: got %b expected 0", bus.o_uart_data_valid); end
    endtask

    task automatic test_glitch();
        int r0, e0, o0;
        r0 = n_rise; e0 = n_err; o0 = n_ovr;
        wait_tick();
        #1 rx = 1'b0;
        repeat (3) wait_tick();
        @(negedge clk);
        n_vec++; if (bus.o_uart_busy !== 1'b1) begin n_mis++; $display("[TB] FAIL glitch_busy_high: got %b expected 1", bus.o_uart_busy); end
        repeat (2) wait_tick();
        #1 rx = 1'b1;
        repeat (12) wait_tick();
        @(negedge clk);
        n_vec++; if (bus.o_uart_busy !== 1'b0) begin n_mis++; $display("[TB] FAIL glitch_busy_low: got %b expected 0", bus.o_uart_busy); end
        n_vec++; if (n_rise - r0 !== 0) begin n_mis++; $display("[TB] FAIL glitch_valid: got %0d expected 0", n_rise - r0); end
        n_vec++; if ((n_err - e0) + (n_ovr - o0) !== 0) begin n_mis++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", (n_err - e0) + (n_ovr - o0)); end
    endtask

    task automatic test_frame_err();
        int r0, e0;
        r0 = n_rise; e0 = n_err;
        send_frame(7'h12, 1'b0, 1'b0, -1);
        @(negedge clk);
        n_vec++; if (n_err - e0 !== 1) begin n_mis++; $display("[TB] FAIL ferr_pulse: got %0d expected 1", n_err - e0); end
        n_vec++; if (bus.o_uart_data_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL ferr_valid: got %b expected 0", bus.o_uart_data_valid); end
        n_vec++; if (n_rise - r0 !== 0) begin n_mis++; $display("[TB] FAIL ferr_valid_rises: got %0d expected 0", n_rise - r0); end
        repeat (20) wait_tick();
        @(negedge clk);
        n_vec++; if (bus.o_uart_busy !== 1'b0) begin n_mis++; $display("[TB] FAIL ferr_rearm_busy: got %b expected 0", bus.o_uart_busy); end
        rx = 1'b1;
        repeat (4) wait_tick();
        send_frame(7'h34, 1'b1, 1'b0, -1);
        @(negedge clk);
        n_vec++; if (bus.o_uart_data !== 7'h34) begin n_mis++; $display("[TB] FAIL ferr_next_data: got %h expected %h", bus.o_uart_data, 7'h34); end
        n_vec++; if (bus.o_uart_data_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL ferr_next_valid: got %b expected 1", bus.o_uart_data_valid); end
        n_vec++; if (n_err - e0 !== 1) begin n_mis++; $display("[TB] FAIL ferr_next_err: got %0d expected 1", n_err - e0); end
        pulse_ready();
    endtask

    task automatic test_overrun();
        int o0;
        o0 = n_ovr;
        send_frame(7'h0F, 1'b1, 1'b0, -1);
        send_frame(7'h70, 1'b1, 1'b0, -1);
        @(negedge clk);
        n_vec++; if (bus.o_uart_data !== 7'h0F) begin n_mis++; $display("[TB] FAIL ovr_data: got %h expected %h", bus.o_uart_data, 7'h0F); end
        n_vec++; if (bus.o_uart_data_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL ovr_valid: got %b expected 1", bus.o_uart_data_valid); end
        n_vec++; if (n_ovr - o0 !== 1) begin n_mis++; $display("[TB] FAIL ovr_pulse: got %0d expected 1", n_ovr - o0); end
        pulse_ready();
        @(negedge clk);
        n_vec++; if (bus.o_uart_data_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL ovr_consume: got %b expected 0", bus.o_uart_data_valid); end
    endtask

    task automatic test_accept_same_clock();
        int o0;
        o0 = n_ovr;
        send_frame(7'h21, 1'b1, 1'b0, -1);
        send_frame(7'h5A, 1'b1, 1'b1, -1);
        @(negedge clk);
        n_vec++; if (bus.o_uart_data !== 7'h5A) begin n_mis++; $display("[TB] FAIL same_clk_data: got %h expected %h", bus.o_uart_data, 7'h5A); end
        n_vec++; if (bus.o_uart_data_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL same_clk_valid: got %b expected 1", bus.o_uart_data_valid); end
        n_vec++; if (n_ovr - o0 !== 0) begin n_mis++; $display("[TB] FAIL same_clk_overrun: got %0d expected 0", n_ovr - o0); end
        pulse_ready();
    endtask

    task automatic test_reset_midframe();
        int r0, e0, o0;
        send_frame(7'h11, 1'b1, 1'b0, -1);
        r0 = n_rise; e0 = n_err; o0 = n_ovr;
        send_frame(7'h2A, 1'b1, 1'b0, 4 * OS + 6);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.o_uart_data !== 7'h00) begin n_mis++; $display("[TB] FAIL midrst_data: got %h expected %h", bus.o_uart_data, 7'h00); end
        n_vec++; if (bus.o_uart_data_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL midrst_valid: got %b expected 0", bus.o_uart_data_valid); end
        n_vec++; if (bus.o_uart_busy !== 1'b0) begin n_mis++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.o_uart_busy); end
        reset = 1'b0;
        rx = 1'b1;
        repeat (40) wait_tick();
        @(negedge clk);
        n_vec++; if ((n_rise - r0) + (n_err - e0) + (n_ovr - o0) !== 0) begin n_mis++; $display("[TB] FAIL midrst_pulses: got %0d expected 0", (n_rise - r0) + (n_err - e0) + (n_ovr - o0)); end
        send_frame(7'h2A, 1'b1, 1'b0, -1);
        @(negedge clk);
        n_vec++; if (bus.o_uart_data !== 7'h2A) begin n_mis++; $display("[TB] FAIL midrst_next_data: got %h expected %h", bus.o_uart_data, 7'h2A); end
        n_vec++; if (bus.o_uart_data_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL midrst_next_valid: got %b expected 1", bus.o_uart_data_valid); end
        pulse_ready();
    endtask

    task automatic test_loopback();
        logic [N-1:0] exp_q[$];
        logic [N-1:0] w;
        int e0, o0, n;
        en_div = 2;
        repeat (8) @(posedge clk);
        #1;
        bus.i_uart_data_ready = 1'b1;
        rx_q.delete();
        e0 = n_err; o0 = n_ovr;
        for (int i = 0; i < 128; i++) begin
            w = N'($urandom);
            exp_q.push_back(w);
            send_frame(w, 1'b1, 1'b0, -1);
            repeat ($urandom_range(0, 3)) wait_tick();
        end
        repeat (20) wait_tick();
        @(negedge clk);
        n_vec++; if (rx_q.size() !== 128) begin n_mis++; $display("[TB] FAIL loop_count: got %0d expected 128", rx_q.size()); end
        n = (rx_q.size() < 128) ? rx_q.size() : 128;
        for (int i = 0; i < n; i++) begin
            n_vec++; if (rx_q[i] !== exp_q[i]) begin n_mis++; $display("[TB] FAIL loop_word[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        n_vec++; if ((n_err - e0) + (n_ovr - o0) !== 0) begin n_mis++; $display("[TB] FAIL loop_pulses: got %0d expected 0", (n_err - e0) + (n_ovr - o0)); end
        bus.i_uart_data_ready = 1'b0;
    endtask

    initial begin
        bus.i_uart_data_ready = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_accept_same_clock();
        test_reset_midframe();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
